// File: rtl/demux_sequencial_pkg.sv
// demux_sequencial_pkg: shared state, mode and channel constants
package demux_sequencial_pkg;
   typedef enum logic {OCIOSO = 1'b0, RECEBE = 1'b1} estado_t;
   localparam logic MODO_MANUAL = 1'b0;
   localparam logic MODO_AUTO = 1'b1;
   localparam logic [1:0] CH0 = 2'd0;
   localparam logic [1:0] CH1 = 2'd1;
   localparam logic [1:0] CH2 = 2'd2;
   localparam logic [1:0] CH3 = 2'd3;
endpackage

// File: rtl/demux_sequencial_contador_canal.sv
// contador_canal: 2-bit channel counter with clear, load-to-1 and increment
module contador_canal (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load1,
   input  logic       inc,
   output logic [1:0] canal,
   output logic       tc
);
   // clear wins over load, load wins over increment
   always_ff @(posedge clk)
      if (rst || clr) canal <= 2'd0;
      else if (load1) canal <= 2'd1;
      else if (inc) canal <= canal + 2'd1;
   assign tc = canal == 2'd3;
endmodule

// File: rtl/demux_sequencial.sv
// demux_sequencial: registered 1:4 demux with manual select or sync-framed auto sequencing
module demux_sequencial
   import demux_sequencial_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Y,
   input  logic             en,
   input  logic             modo,
   input  logic             sync,
   input  logic             S0,
   input  logic             S1,
   output logic [WIDTH-1:0] D0,
   output logic [WIDTH-1:0] D1,
   output logic [WIDTH-1:0] D2,
   output logic [WIDTH-1:0] D3,
   output logic [1:0]       canal,
   output logic             quadro_ok,
   output logic             erro
);
   estado_t estado, prox;
   logic clr, load1, inc, tc, wr, qok_d, erro_d;
   logic [1:0] sel;
   logic [WIDTH-1:0] d [4];

   contador_canal u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .load1 (load1),
      .inc   (inc),
      .canal (canal),
      .tc    (tc)
   );

   // frame state register
   always_ff @(posedge clk)
      estado <= rst ? OCIOSO : prox;

   // next state, counter control, write strobe and pulse requests
   always_comb begin
      prox = estado;
      clr = 1'b0;
      load1 = 1'b0;
      inc = 1'b0;
      wr = 1'b0;
      sel = CH0;
      qok_d = 1'b0;
      erro_d = 1'b0;
      if (modo == MODO_MANUAL) begin
         prox = OCIOSO;
         clr = 1'b1;
         wr = en;
         sel = {S1, S0};
      end else if (en && sync) begin
         prox = RECEBE;
         load1 = 1'b1;
         wr = 1'b1;
         erro_d = estado == RECEBE;
      end else if (en && estado == RECEBE) begin
         prox = tc ? OCIOSO : RECEBE;
         inc = 1'b1;
         wr = 1'b1;
         sel = canal;
         qok_d = tc;
      end
   end

   // channel registers and status pulses
   always_ff @(posedge clk)
      if (rst) begin
         d <= '{default: '0};
         quadro_ok <= 1'b0;
         erro <= 1'b0;
      end else begin
         quadro_ok <= qok_d;
         erro <= erro_d;
         if (wr) d[sel] <= Y;
      end

   assign D0 = d[0];
   assign D1 = d[1];
   assign D2 = d[2];
   assign D3 = d[3];
endmodule

// File: tb/tb_demux_sequencial.sv
// tb_demux_sequencial: table vectors, directed corner sequences and randomized model checks
module tb_demux_sequencial;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst, en, modo, sync, S0, S1;
   logic [W-1:0] Y, D0, D1, D2, D3;
   logic [1:0] canal;
   logic quadro_ok, erro;

   demux_sequencial #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .Y(Y), .en(en), .modo(modo), .sync(sync),
      .S0(S0), .S1(S1), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
      .canal(canal), .quadro_ok(quadro_ok), .erro(erro)
   );

   always #5 clk = ~clk;

   int passed = 0, total = 0, cyc = 0;
   logic [W-1:0] md [4];
   int mslot = 0;
   bit mbusy = 0, mq = 0, me = 0;

   typedef struct {
      bit r, e, m, sy;
      bit [1:0] s;
      logic [W-1:0] y, d0, d1, d2, d3;
      int c;
      bit q, er;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(bit r, e, m, sy, bit [1:0] s, int y, d0, d1, d2, d3, c, bit q, er);
      vec_t v;
      v.r = r; v.e = e; v.m = m; v.sy = sy; v.s = s; v.y = W'(y);
      v.d0 = W'(d0); v.d1 = W'(d1); v.d2 = W'(d2); v.d3 = W'(d3);
      v.c = c; v.q = q; v.er = er;
      return v;
   endfunction

   task automatic chk(input string n, input int a, input int e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s @cyc %0d: got %0d expected %0d", n, cyc, a, e);
   endtask

   task automatic step(input bit r, e, m, sy, input bit [1:0] s, input logic [W-1:0] y);
      rst = r; en = e; modo = m; sync = sy; {S1, S0} = s; Y = y;
      @(posedge clk);
      #1;
      cyc++;
      mq = 0; me = 0;
      if (r) begin
         md = '{default: '0}; mslot = 0; mbusy = 0;
      end else if (!m) begin
         mbusy = 0; mslot = 0;
         if (e) md[s] = y;
      end else if (e && sy) begin
         me = mbusy; md[0] = y; mslot = 1; mbusy = 1;
      end else if (e && mbusy) begin
         md[mslot] = y;
         if (mslot == 3) begin mq = 1; mslot = 0; mbusy = 0; end
         else mslot++;
      end
   endtask

   task automatic chk_model(input string t);
      chk({t, " D0"}, int'(D0), int'(md[0]));
      chk({t, " D1"}, int'(D1), int'(md[1]));
      chk({t, " D2"}, int'(D2), int'(md[2]));
      chk({t, " D3"}, int'(D3), int'(md[3]));
      chk({t, " canal"}, int'(canal), mslot);
      chk({t, " quadro_ok"}, int'(quadro_ok), int'(mq));
      chk({t, " erro"}, int'(erro), int'(me));
   endtask

   initial begin
      int q1, q2, nq;
      vecs.push_back(mk(1,0,0,0,0, 0,  0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,0,0,0, 1,  1,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,0,0,1, 0,  1,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,0,0,2, 1,  1,0,1,0, 0,0,0));
      vecs.push_back(mk(0,1,0,0,3, 1,  1,0,1,1, 0,0,0));
      vecs.push_back(mk(0,1,1,1,2, 1,  1,0,1,1, 1,0,0));
      vecs.push_back(mk(0,1,1,0,3, 1,  1,1,1,1, 2,0,0));
      vecs.push_back(mk(0,1,1,0,0, 0,  1,1,0,1, 3,0,0));
      vecs.push_back(mk(0,1,1,0,1, 1,  1,1,0,1, 0,1,0));
      vecs.push_back(mk(0,0,1,0,0, 9,  1,1,0,1, 0,0,0));
      vecs.push_back(mk(0,1,1,0,0, 15, 1,1,0,1, 0,0,0));
      vecs.push_back(mk(0,1,1,1,0, 5,  5,1,0,1, 1,0,0));
      vecs.push_back(mk(0,1,1,0,0, 6,  5,6,0,1, 2,0,0));
      vecs.push_back(mk(0,1,1,1,0, 7,  7,6,0,1, 1,0,1));
      vecs.push_back(mk(0,1,1,0,0, 8,  7,8,0,1, 2,0,0));
      vecs.push_back(mk(0,1,1,0,0, 9,  7,8,9,1, 3,0,0));
      vecs.push_back(mk(0,1,1,0,0, 10, 7,8,9,10, 0,1,0));
      vecs.push_back(mk(0,1,1,0,3, 12, 7,8,9,10, 0,0,0));
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].sy, vecs[i].s, vecs[i].y);
         chk($sformatf("vec%0d D0", i), int'(D0), int'(vecs[i].d0));
         chk($sformatf("vec%0d D1", i), int'(D1), int'(vecs[i].d1));
         chk($sformatf("vec%0d D2", i), int'(D2), int'(vecs[i].d2));
         chk($sformatf("vec%0d D3", i), int'(D3), int'(vecs[i].d3));
         chk($sformatf("vec%0d canal", i), int'(canal), vecs[i].c);
         chk($sformatf("vec%0d quadro_ok", i), int'(quadro_ok), int'(vecs[i].q));
         chk($sformatf("vec%0d erro", i), int'(erro), int'(vecs[i].er));
      end

      step(0,1,1,1,0, 3); chk_model("stall b0");
      step(0,1,1,0,0, 4); chk_model("stall b1");
      for (int i = 0; i < 3; i++) begin
         step(0,0,1,0,0, 4'hF); chk_model("stall hold");
         chk("stall canal", int'(canal), 2);
      end
      step(0,1,1,0,0, 2); chk_model("stall b2");
      chk("stall no early qok", int'(quadro_ok), 0);
      step(0,1,1,0,0, 1); chk_model("stall b3");
      chk("stall qok", int'(quadro_ok), 1);
      step(0,0,1,0,0, 0); chk("stall qok single", int'(quadro_ok), 0);

      step(0,1,1,1,0, 11); chk_model("abort b0");
      step(0,1,1,0,0, 12); chk_model("abort b1");
      step(0,1,0,0,2, 13); chk_model("abort manual");
      chk("abort canal", int'(canal), 0);
      chk("abort D2 write", int'(D2), 13);
      step(0,1,1,0,0, 14); chk_model("abort discard");
      chk("abort idle canal", int'(canal), 0);

      step(0,1,1,1,0, 6); chk_model("rst b0");
      step(0,1,1,0,0, 7); chk_model("rst b1");
      step(1,1,1,0,0, 8); chk_model("rst mid");
      chk("rst D0", int'(D0), 0);
      chk("rst D1", int'(D1), 0);
      chk("rst canal", int'(canal), 0);
      step(0,1,1,1,0, 1); chk_model("rst f0");
      step(0,1,1,0,0, 2); chk_model("rst f1");
      step(0,1,1,0,0, 3); chk_model("rst f2");
      step(0,1,1,0,0, 4); chk_model("rst f3");
      chk("rst frame qok", int'(quadro_ok), 1);

      q1 = -1; q2 = -1; nq = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 1, (i % 4) == 0 && i < 8, 0, W'(i + 3));
         chk_model("b2b");
         if (quadro_ok) begin
            nq++;
            if (q1 < 0) q1 = cyc; else q2 = cyc;
         end
      end
      chk("b2b pulse count", nq, 2);
      chk("b2b spacing", q2 - q1, 4);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
              2'($urandom_range(0, 3)), W'($urandom));
         chk_model("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/demux_sequencial.md
Name: demux_sequencial

Overview:
- 1:4 registered demultiplexer. It is the receive-side counterpart of the 4:1 mux used in the practical-activity datapath.
- A single data input Y is distributed to four held outputs D0..D3.
- Channel selection is either manual (select inputs S1,S0) or automatic (an internal 2-bit counter stepping through a 4-slot frame that starts on a sync pulse).
- It sits downstream of the mux so the pair forms a loopback for lab benches.

Parameters:
WIDTH, 1, bit width of Y and of each output D0..D3

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
Y  input  WIDTH  data to be demultiplexed
en  input  1  data valid; Y is consumed only on cycles with en=1
modo  input  1  0 = manual select via S1,S0; 1 = automatic framed sequencing
sync  input  1  frame start marker, meaningful only when modo=1 and en=1
S0  input  1  manual select LSB (ignored when modo=1)
S1  input  1  manual select MSB (ignored when modo=1)
D0  output  WIDTH  registered channel 0
D1  output  WIDTH  registered channel 1
D2  output  WIDTH  registered channel 2
D3  output  WIDTH  registered channel 3
canal  output  2  channel the next auto-mode write targets (counter value)
quadro_ok  output  1  1-cycle pulse: auto-mode frame D0..D3 completely written
erro  output  1  1-cycle pulse: auto-mode frame truncated by a new sync

Behaviour:
- Reset (rst=1 at rising edge):
  - D0..D3 = 0; canal = 0; quadro_ok = 0; erro = 0; FSM = OCIOSO.
  - rst overrides every other input.
- Latency: each write is visible on Dn one clock after the accepting edge. Unwritten outputs hold their value.
- quadro_ok and erro are registered. Both default to 0 every cycle unless set as described below.
- Manual mode (modo=0):
  - en=1: D[{S1,S0}] <= Y at the edge. S1 is the MSB (S1=0,S0=1 selects D1).
  - en=0: no change.
  - FSM is forced to OCIOSO and canal = 0. quadro_ok and erro stay 0.
- Auto mode (modo=1), FSM states OCIOSO and RECEBE:
  - OCIOSO:
    - en=1 & sync=1: D0 <= Y, canal <= 1, go to RECEBE.
    - en=1 & sync=0: data discarded, stay in OCIOSO.
    - en=0: hold.
  - RECEBE:
    - en=0: hold (stalls are allowed indefinitely).
    - en=1 & sync=0: D[canal] <= Y, canal <= canal+1.
      - If canal==3 at this edge: quadro_ok <= 1, canal wraps to 0, go to OCIOSO.
    - en=1 & sync=1: frame restart. D0 <= Y, canal <= 1, erro <= 1, stay in RECEBE.
      - Already-written D1..D3 keep their stale values. No quadro_ok.
- Back-to-back frames: a sync with en=1 in the cycle immediately after quadro_ok is accepted normally from OCIOSO. There is no dead cycle.
- Mode change:
  - modo 1->0 mid-frame: abort. FSM -> OCIOSO, canal -> 0, no pulses. The manual write for that cycle is still performed if en=1.
  - modo 0->1: starts in OCIOSO and waits for sync.
- Counter: 2-bit, wraps 3->0 only on frame completion. It never increments when en=0.
- No combinational path from inputs to any output. All outputs are flops.

Decomposition:
- Shared package/header (demux_defs.vh):
  - State encodings OCIOSO=1'b0, RECEBE=1'b1.
  - Mode constants MODO_MANUAL=0, MODO_AUTO=1.
  - Channel constants CH0..CH3.
- One natural sub-module: contador_canal. This is the 2-bit counter with enable, synchronous clear and load-to-1, outputting canal and a terminal-count flag (canal==3).
- The top level holds the FSM, output registers and pulse flops.

Test Plan:
1. Reset then manual: rst=1 one cycle; modo=0, en=1, (S1,S0)=00,01,10,11 with Y=1,0,1,1. Required: D0..D3 = 1,0,1,1 one cycle after each respective edge; canal=0; no pulses.
2. Auto full frame: modo=1; en=1 with sync=1 on slot 0, then 3 more beats with Y=1,1,0,1. Required: D0..D3 = 1,1,0,1; canal steps 1,2,3,0; quadro_ok=1 exactly one cycle, after the 4th beat.
3. Stall: same frame with en=0 for 3 cycles between beats 2 and 3. Required: canal holds at 2; outputs unchanged during the stall; quadro_ok is delayed accordingly and still a single pulse.
4. Truncation: sync=1 again on beat 3 of a frame. Required: erro=1 for one cycle; D0 takes the new Y; canal=1; no quadro_ok until 3 further non-sync beats.
5. Abort/reset mid-frame:
   - modo->0 after 2 auto beats: required FSM returns to OCIOSO, canal=0, no pulses.
   - Separately, rst=1 mid-frame: required all D=0, canal=0 next cycle, and a later frame completes normally.
6. Back-to-back frames plus discard: two consecutive framed bursts with no gap. Required: two quadro_ok pulses exactly 4 cycles apart. Beats with en=1 and sync=0 in OCIOSO leave D unchanged.
